// File: rtl/id_ex_forward_stage_if.sv
// ID/EX stage bus: ID-side instruction fields, backend control, EX/MEM and MEM/WB
// destinations in; registered EX fields, forwarding selects and upstream stall out.
interface id_ex_forward_stage_if #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
);
  logic             id_valid;
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic [RA_W-1:0]  id_rd_dst;
  logic             id_reg_write;
  logic             id_mem_read;
  logic [WIDTH-1:0] id_rs_val;
  logic [WIDTH-1:0] id_rt_val;
  logic             stall_in;
  logic             flush;
  logic [RA_W-1:0]  exm_rd;
  logic             exm_reg_write;
  logic [RA_W-1:0]  mwb_rd;
  logic             mwb_reg_write;

  logic             ex_valid;
  logic [RA_W-1:0]  ex_rs;
  logic [RA_W-1:0]  ex_rt;
  logic [RA_W-1:0]  ex_rd_dst;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [WIDTH-1:0] ex_rs_val;
  logic [WIDTH-1:0] ex_rt_val;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             id_stall;

  modport master (
    output id_valid, id_rs, id_rt, id_rd_dst, id_reg_write, id_mem_read,
           id_rs_val, id_rt_val, stall_in, flush,
           exm_rd, exm_reg_write, mwb_rd, mwb_reg_write,
    input  ex_valid, ex_rs, ex_rt, ex_rd_dst, ex_reg_write, ex_mem_read,
           ex_rs_val, ex_rt_val, fwd_a_sel, fwd_b_sel, id_stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd_dst, id_reg_write, id_mem_read,
           id_rs_val, id_rt_val, stall_in, flush,
           exm_rd, exm_reg_write, mwb_rd, mwb_reg_write,
    output ex_valid, ex_rs, ex_rt, ex_rd_dst, ex_reg_write, ex_mem_read,
           ex_rs_val, ex_rt_val, fwd_a_sel, fwd_b_sel, id_stall
  );
endinterface

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with operand forwarding selects and load-use bubble insertion
// for the 5-stage MIPS core.
module id_ex_forward_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input logic                   clk,
  input logic                   rst,
  id_ex_forward_stage_if.slave  bus
);

  logic             ex_valid_r;
  logic [RA_W-1:0]  ex_rs_r;
  logic [RA_W-1:0]  ex_rt_r;
  logic [RA_W-1:0]  ex_rd_dst_r;
  logic             ex_reg_write_r;
  logic             ex_mem_read_r;
  logic [WIDTH-1:0] ex_rs_val_r;
  logic [WIDTH-1:0] ex_rt_val_r;

  logic             lu_s;
  logic             id_stall_s;
  logic             bubble_s;
  logic [1:0]       fwd_a_sel_s;
  logic [1:0]       fwd_b_sel_s;

  // EX/MEM holds the youngest value so it is checked first; $0 never forwards.
  function automatic logic [1:0] fwd_sel_f(
    input logic            valid,
    input logic [RA_W-1:0] src,
    input logic            exm_we,
    input logic [RA_W-1:0] exm_rd,
    input logic            mwb_we,
    input logic [RA_W-1:0] mwb_rd
  );
    logic [1:0] sel;
    if (valid && exm_we && (exm_rd != {RA_W{1'b0}}) && (exm_rd == src)) begin
      sel = 2'b01;
    end else if (valid && mwb_we && (mwb_rd != {RA_W{1'b0}}) && (mwb_rd == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Load-use detection, upstream stall and forwarding selects.
  always_comb begin
    lu_s        = 1'b0;
    id_stall_s  = 1'b0;
    bubble_s    = 1'b0;
    fwd_a_sel_s = 2'b00;
    fwd_b_sel_s = 2'b00;

    lu_s = ex_valid_r && ex_mem_read_r && (ex_rd_dst_r != {RA_W{1'b0}}) && bus.id_valid &&
           ((bus.id_rs == ex_rd_dst_r) || (bus.id_rt == ex_rd_dst_r));
    // A flushed consumer is being killed upstream, so it need not be held.
    id_stall_s = bus.stall_in || (lu_s && !bus.flush);
    // A backend freeze outranks the load-use bubble; the hazard is re-seen afterwards.
    bubble_s   = bus.flush || (lu_s && !bus.stall_in);

    fwd_a_sel_s = fwd_sel_f(ex_valid_r, ex_rs_r, bus.exm_reg_write, bus.exm_rd,
                            bus.mwb_reg_write, bus.mwb_rd);
    fwd_b_sel_s = fwd_sel_f(ex_valid_r, ex_rt_r, bus.exm_reg_write, bus.exm_rd,
                            bus.mwb_reg_write, bus.mwb_rd);
  end

  // ID/EX register: reset or bubble clears, freeze holds, otherwise capture ID.
  always_ff @(posedge clk) begin
    if (rst || bubble_s) begin
      ex_valid_r     <= 1'b0;
      ex_rs_r        <= {RA_W{1'b0}};
      ex_rt_r        <= {RA_W{1'b0}};
      ex_rd_dst_r    <= {RA_W{1'b0}};
      ex_reg_write_r <= 1'b0;
      ex_mem_read_r  <= 1'b0;
      ex_rs_val_r    <= {WIDTH{1'b0}};
      ex_rt_val_r    <= {WIDTH{1'b0}};
    end else if (!bus.stall_in) begin
      ex_valid_r     <= bus.id_valid;
      ex_rs_r        <= bus.id_rs;
      ex_rt_r        <= bus.id_rt;
      ex_rd_dst_r    <= bus.id_rd_dst;
      ex_reg_write_r <= bus.id_reg_write && bus.id_valid;
      ex_mem_read_r  <= bus.id_mem_read && bus.id_valid;
      ex_rs_val_r    <= bus.id_rs_val;
      ex_rt_val_r    <= bus.id_rt_val;
    end
  end

  assign bus.ex_valid     = ex_valid_r;
  assign bus.ex_rs        = ex_rs_r;
  assign bus.ex_rt        = ex_rt_r;
  assign bus.ex_rd_dst    = ex_rd_dst_r;
  assign bus.ex_reg_write = ex_reg_write_r;
  assign bus.ex_mem_read  = ex_mem_read_r;
  assign bus.ex_rs_val    = ex_rs_val_r;
  assign bus.ex_rt_val    = ex_rt_val_r;
  assign bus.fwd_a_sel    = fwd_a_sel_s;
  assign bus.fwd_b_sel    = fwd_b_sel_s;
  assign bus.id_stall     = id_stall_s;

endmodule
